// File: rtl/aes_decrypt_core_if.sv
`default_nettype none
// ============================================================================
// Module   : aes_decrypt_core_if
// Purpose  : Bundles the start/hold request, ciphertext and round-key inputs
//            and the round-index / result outputs of the AES-128 decrypt core.
// Ports    : en         - start/hold request (level)
//            ciphertext - 128-bit block to decrypt, AES byte 0 in [127:120]
//            round_key  - round key for the index on 'round' (same cycle)
//            round      - index 10..0 of the round key needed this cycle
//            plaintext  - decrypted block, registered
//            done_d     - result-valid flag, registered
// Modports : master - requester / key store side
//            slave  - decrypt core side
// Revision : 1.0 - initial release
// ============================================================================
interface aes_decrypt_core_if;
  logic         en;
  logic [127:0] ciphertext;
  logic [127:0] round_key;
  logic [3:0]   round;
  logic [127:0] plaintext;
  logic         done_d;

  modport master (
    output en, ciphertext, round_key,
    input  round, plaintext, done_d
  );

  modport slave (
    input  en, ciphertext, round_key,
    output round, plaintext, done_d
  );
endinterface
`default_nettype wire

// File: rtl/aes_decrypt_core.sv
`default_nettype none
// ============================================================================
// Module   : aes_decrypt_core
// Purpose  : Iterative AES-128 inverse cipher, one round per clock. Round keys
//            come from an external key-expansion store addressed by 'round'.
// Ports    : clk  - single clock, rising edge
//            trst - synchronous active-low reset
//            bus  - aes_decrypt_core_if.slave (en, ciphertext, round_key in;
//                   round, plaintext, done_d out)
// Revision : 1.0 - initial release
// ============================================================================
module aes_decrypt_core (
  input  logic              clk,
  input  logic              trst,
  aes_decrypt_core_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  // Inverse S-box, row-major: entry x lives at bits [2047-8x -: 8].
  localparam logic [2047:0] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  fsm_t         fsm_q;
  logic [127:0] state_q;
  logic [127:0] plaintext_q;
  logic [3:0]   round_q;
  logic         done_q;

  logic [127:0] shift_w;
  logic [127:0] sub_w;
  logic [127:0] final_d;  // InvShiftRows -> InvSubBytes -> AddRoundKey
  logic [127:0] round_d;  // final_d followed by InvMixColumns

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [10:0] idx;
    idx = 11'h7ff - {x, 3'b000};
    return INV_SBOX_TBL[idx -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Column in AES order: byte 0 (row 0) in [31:24].
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2    = xtime(a[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  // Byte k sits at [127-8k -: 8]; row = k%4, column = k/4.
  // Row r rotates right by r: new[r][c] = old[r][(c-r) mod 4].
  always_comb begin
    shift_w = '0;
    sub_w   = '0;
    round_d = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shift_w[127-8*(4*c+r) -: 8] = state_q[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
    for (int k = 0; k < 16; k++) begin
      sub_w[127-8*k -: 8] = inv_sbox(shift_w[127-8*k -: 8]);
    end
    final_d = sub_w ^ bus.round_key;
    for (int c = 0; c < 4; c++) begin
      round_d[127-32*c -: 32] = inv_mix_col(final_d[127-32*c -: 32]);
    end
  end

  always_ff @(posedge clk) begin
    if (!trst) begin
      fsm_q       <= IDLE;
      round_q     <= 4'd10;
      done_q      <= 1'b0;
      plaintext_q <= '0;
      state_q     <= '0;
    end else begin
      case (fsm_q)
        IDLE: begin
          round_q <= 4'd10;
          done_q  <= 1'b0;
          if (bus.en) begin
            // round_key is rk10 here since round reads 10 in IDLE
            state_q <= bus.ciphertext ^ bus.round_key;
            round_q <= 4'd9;
            fsm_q   <= RUN;
          end
        end
        RUN: begin
          if (!bus.en) begin
            round_q <= 4'd10;
            fsm_q   <= IDLE;
          end else if (round_q == 4'd0) begin
            plaintext_q <= final_d;
            done_q      <= 1'b1;
            fsm_q       <= DONE;
          end else begin
            state_q <= round_d;
            round_q <= round_q - 4'd1;
          end
        end
        DONE: begin
          if (!bus.en) begin
            done_q  <= 1'b0;
            round_q <= 4'd10;
            fsm_q   <= IDLE;
          end
        end
        default: begin
          round_q <= 4'd10;
          done_q  <= 1'b0;
          fsm_q   <= IDLE;
        end
      endcase
    end
  end

  assign bus.round     = round_q;
  assign bus.plaintext = plaintext_q;
  assign bus.done_d    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_decrypt_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_decrypt_core
// Purpose  : Self-checking bench for aes_decrypt_core. Supplies round keys
//            from a key schedule computed here, runs known-answer vectors
//            from a table, then abort and mid-run reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_decrypt_core;

  logic clk;
  logic trst;
  int   total;
  int   bad;

  logic [127:0] rk [0:10];

  aes_decrypt_core_if bus();

  aes_decrypt_core dut (
    .clk  (clk),
    .trst (trst),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External key store: combinational lookup on the requested index.
  always_comb begin
    bus.round_key = '0;
    if (bus.round <= 4'd10) bus.round_key = rk[bus.round];
  end

  // ---------------- forward-cipher reference model ----------------
  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xt(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse then affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] v;
    v = 8'h01;
    for (int i = 0; i < 254; i++) v = gm(v, x);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
             ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [1407:0] expand(input logic [127:0] key);
    logic [31:0]   w [0:43];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1407:0] o;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    o = '0;
    for (int i = 0; i < 44; i++) o[1407-32*i -: 32] = w[i];
    return o;
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [127:0] key);
    logic [1407:0] ks;
    logic [127:0]  s, n;
    logic [7:0]    a0, a1, a2, a3;
    ks = expand(key);
    s  = pt ^ ks[1407 -: 128];
    for (int r = 1; r <= 10; r++) begin
      for (int k = 0; k < 16; k++) s[127-8*k -: 8] = sbox(s[127-8*k -: 8]);
      n = '0;
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++)
          n[127-8*(4*c+w) -: 8] = s[127-8*(4*((c+w)%4)+w) -: 8];
      s = n;
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[127-32*c -: 8];  a1 = s[119-32*c -: 8];
          a2 = s[111-32*c -: 8];  a3 = s[103-32*c -: 8];
          s[127-32*c -: 32] = {gm(a0,8'h02) ^ gm(a1,8'h03) ^ a2 ^ a3,
                               a0 ^ gm(a1,8'h02) ^ gm(a2,8'h03) ^ a3,
                               a0 ^ a1 ^ gm(a2,8'h02) ^ gm(a3,8'h03),
                               gm(a0,8'h03) ^ a1 ^ a2 ^ gm(a3,8'h02)};
        end
      end
      s = s ^ ks[1407-128*r -: 128];
    end
    return s;
  endfunction

  task automatic set_key(input logic [127:0] key);
    logic [1407:0] ks;
    ks = expand(key);
    for (int r = 0; r <= 10; r++) rk[r] = ks[1407-128*r -: 128];
  endtask

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1 with the core idle. Runs one block to completion,
  // checks round sequencing, latency, result, DONE hold and return to IDLE.
  task automatic run_vector(input int id, input logic [127:0] key,
                            input logic [127:0] ct, input logic [127:0] pt);
    int cyc;
    int seq_err;
    string tag;
    tag = $sformatf("vec%0d", id);
    set_key(key);
    bus.ciphertext = ct;
    bus.en         = 1'b1;
    check({tag, "_pre_round"}, 128'(bus.round), 128'd10);
    cyc = 0;
    seq_err = 0;
    do begin
      tick();
      cyc++;
      if (cyc == 1) bus.ciphertext = ~ct;  // must not disturb the running block
      if (!bus.done_d && bus.round != 4'(10 - cyc)) seq_err++;
    end while (!bus.done_d && cyc < 20);
    check({tag, "_round_seq"}, 128'(seq_err), 128'd0);
    check({tag, "_latency"}, 128'(cyc), 128'd11);
    check({tag, "_plaintext"}, bus.plaintext, pt);
    check({tag, "_done_round"}, 128'(bus.round), 128'd0);
    tick();
    check({tag, "_hold_done"}, 128'(bus.done_d), 128'd1);
    check({tag, "_hold_pt"}, bus.plaintext, pt);
    check({tag, "_hold_round"}, 128'(bus.round), 128'd0);
    bus.en = 1'b0;
    tick();
    check({tag, "_exit_done"}, 128'(bus.done_d), 128'd0);
    check({tag, "_exit_round"}, 128'(bus.round), 128'd10);
    tick();
    check({tag, "_idle_pt"}, bus.plaintext, pt);
  endtask

  typedef struct {
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT7   = 128'h00000000000000000000000000000007;

  initial begin
    vec_t         vecs [4];
    logic [127:0] ct7;
    logic [127:0] prev_pt;
    int           done_seen;
    int           n;

    total = 0;
    bad   = 0;
    for (int r = 0; r <= 10; r++) rk[r] = '0;

    ct7 = encrypt(PT7, KEY_C);
    vecs[0] = '{KEY_B, 128'h3925841d02dc09fbdc118597196a0b32,
                       128'h3243f6a8885a308d313198a2e0370734};
    vecs[1] = '{KEY_C, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                       128'h00112233445566778899aabbccddeeff};
    vecs[2] = '{KEY_C, ct7, PT7};
    vecs[3] = '{128'hffeeddccbbaa99887766554433221100,
                encrypt(128'h0123456789abcdeffedcba9876543210,
                        128'hffeeddccbbaa99887766554433221100),
                128'h0123456789abcdeffedcba9876543210};

    // Reset: two edges with trst low, en asserted to show it is overridden
    trst = 1'b0;
    bus.en = 1'b1;
    bus.ciphertext = vecs[0].ct;
    repeat (2) tick();
    check("rst_round", 128'(bus.round), 128'd10);
    check("rst_done", 128'(bus.done_d), 128'd0);
    check("rst_pt", bus.plaintext, 128'd0);
    bus.en = 1'b0;
    trst = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) run_vector(i, vecs[i].key, vecs[i].ct, vecs[i].pt);

    // Abort: 5 RUN edges then en low
    prev_pt = vecs[3].pt;
    set_key(KEY_C);
    bus.ciphertext = ct7;
    bus.en = 1'b1;
    done_seen = 0;
    tick();
    repeat (5) begin
      tick();
      if (bus.done_d) done_seen++;
    end
    check("abort_round_before", 128'(bus.round), 128'd4);
    bus.en = 1'b0;
    tick();
    if (bus.done_d) done_seen++;
    check("abort_round", 128'(bus.round), 128'd10);
    check("abort_pt", bus.plaintext, prev_pt);
    repeat (3) begin
      tick();
      if (bus.done_d) done_seen++;
    end
    check("abort_done_never", 128'(done_seen), 128'd0);
    check("abort_idle_round", 128'(bus.round), 128'd10);
    check("abort_pt_kept", bus.plaintext, prev_pt);

    // Reset mid-run at round 4, then immediate restart
    bus.en = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.round != 4'd4 && n < 15);
    check("midrst_reach_r4", 128'(bus.round), 128'd4);
    trst = 1'b0;
    tick();
    check("midrst_round", 128'(bus.round), 128'd10);
    check("midrst_done", 128'(bus.done_d), 128'd0);
    check("midrst_pt", bus.plaintext, 128'd0);
    trst = 1'b1;
    run_vector(9, KEY_C, ct7, PT7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
